cdb_arbiter: RTL and testbench

Shares the CDB_SIZE common-data-bus lanes among N_REQ functional-unit requesters (alu_rs, mul_rs, branch_rs, load unit). Each requester presents a result through a valid/ready handshake. Up to CDB_SIZE requests are granted per cycle using a rotating round-robin priority. Granted results are registered onto the CDB one cycle later, where the reservation stations and ROB snoop them.

---
 rtl/rv32i_types.sv | 16 +
 rtl/cdb_arbiter_rr_multi_select.sv | 62 ++++++
 rtl/cdb_arbiter.sv | 109 ++++++++++
 tb/tb_cdb_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types for the common data bus
// Purpose: shared package holding the CDB lane entry type and its field widths.
// Ports: none (package).
package rv32i_types;

    // ROB index width carried on the CDB; cdb_arbiter's ROB_DEPTH defaults to this.
    localparam int ROB_IDX_W = 3;
    localparam int XLEN      = 32;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob;
        logic [XLEN-1:0]      v;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_rr_multi_select.sv
// rtl/cdb_arbiter_rr_multi_select.sv - combinational multi-grant round-robin picker
// Purpose: starting at ptr_i, walk the requesters circularly and grant the first
//          CDB_SIZE active ones, packing them onto lanes in scan order.
// Ports:
//   req_i        requests (already masked by the caller)
//   ptr_i        requester index with highest priority this cycle
//   grant_o      one-hot-per-requester grant vector
//   lane_idx_o   requester index feeding each lane
//   lane_valid_o lane carries a grant
//   last_idx_o   index of the last requester granted in scan order
//   any_grant_o  at least one grant this cycle
module rr_multi_select #(
    parameter int N_REQ    = 4,
    parameter int CDB_SIZE = 3,
    parameter int IDX_W    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]    req_i,
    input  logic [IDX_W-1:0]    ptr_i,
    output logic [N_REQ-1:0]    grant_o,
    output logic [IDX_W-1:0]    lane_idx_o [CDB_SIZE],
    output logic [CDB_SIZE-1:0] lane_valid_o,
    output logic [IDX_W-1:0]    last_idx_o,
    output logic                any_grant_o
);

    always_comb begin
        int cnt;
        int j;
        grant_o      = '0;
        lane_valid_o = '0;
        last_idx_o   = '0;
        for (int l = 0; l < CDB_SIZE; l++) begin
            lane_idx_o[l] = '0;
        end
        cnt = 0;
        j   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            // Circular scan position; ptr is always < N_REQ so one subtraction wraps it.
            j = int'(ptr_i) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            // Compare loops keep every array select at a constant index.
            for (int r = 0; r < N_REQ; r++) begin
                if (r == j && req_i[r] && cnt < CDB_SIZE) begin
                    grant_o[r] = 1'b1;
                    last_idx_o = IDX_W'(r);
                    for (int l = 0; l < CDB_SIZE; l++) begin
                        if (l == cnt) begin
                            lane_idx_o[l]   = IDX_W'(r);
                            lane_valid_o[l] = 1'b1;
                        end
                    end
                    cnt = cnt + 1;
                end
            end
        end
    end

    assign any_grant_o = |grant_o;

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter sharing CDB lanes among functional units
// Purpose: grants up to CDB_SIZE of N_REQ results per cycle with rotating priority
//          and registers the granted results onto the CDB lanes one cycle later.
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   move_flush   pipeline flush: blocks grants now, clears lanes and pointer next cycle
//   req_valid    per-requester result valid
//   req_rob      per-requester destination ROB index
//   req_v        per-requester result value
//   req_ready    per-requester combinational grant
//   cdb_valid    per-lane broadcast valid (registered)
//   cdb_rob      per-lane ROB index (registered)
//   cdb_rd_v     per-lane result value (registered)
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int N_REQ     = 4,
    parameter int CDB_SIZE  = 3,
    parameter int ROB_DEPTH = ROB_IDX_W   // must match the package ROB index width
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 move_flush,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [ROB_DEPTH-1:0] req_rob   [N_REQ],
    input  logic [31:0]          req_v     [N_REQ],
    output logic [N_REQ-1:0]     req_ready,
    output logic [CDB_SIZE-1:0]  cdb_valid,
    output logic [ROB_DEPTH-1:0] cdb_rob   [CDB_SIZE],
    output logic [31:0]          cdb_rd_v  [CDB_SIZE]
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    cdb_entry_t          lane_q [CDB_SIZE];
    cdb_entry_t          lane_d [CDB_SIZE];

    logic [N_REQ-1:0]    req_masked;
    logic [N_REQ-1:0]    grant;
    logic [IDX_W-1:0]    lane_idx [CDB_SIZE];
    logic [CDB_SIZE-1:0] lane_valid;
    logic [IDX_W-1:0]    last_idx;
    logic                any_grant;

    // Nothing is consumed during reset or flush, so requesters keep their results.
    assign req_masked = (rst || move_flush) ? '0 : req_valid;

    rr_multi_select #(
        .N_REQ    (N_REQ),
        .CDB_SIZE (CDB_SIZE),
        .IDX_W    (IDX_W)
    ) u_select (
        .req_i        (req_masked),
        .ptr_i        (rr_ptr_q),
        .grant_o      (grant),
        .lane_idx_o   (lane_idx),
        .lane_valid_o (lane_valid),
        .last_idx_o   (last_idx),
        .any_grant_o  (any_grant)
    );

    assign req_ready = grant;

    // Unused lanes are driven all-zero rather than left holding stale data.
    always_comb begin
        for (int l = 0; l < CDB_SIZE; l++) begin
            lane_d[l] = '0;
            if (lane_valid[l]) begin
                lane_d[l].valid = 1'b1;
                lane_d[l].rob   = ROB_IDX_W'(req_rob[lane_idx[l]]);
                lane_d[l].v     = req_v[lane_idx[l]];
            end
        end
    end

    // Priority resumes just past the last winner so skipped requesters go first next time.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (move_flush) begin
            rr_ptr_d = '0;
        end else if (any_grant) begin
            rr_ptr_d = (last_idx == IDX_W'(N_REQ - 1)) ? '0 : last_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            for (int l = 0; l < CDB_SIZE; l++) begin
                lane_q[l] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int l = 0; l < CDB_SIZE; l++) begin
                lane_q[l] <= lane_d[l];
            end
        end
    end

    always_comb begin
        for (int l = 0; l < CDB_SIZE; l++) begin
            cdb_valid[l] = lane_q[l].valid;
            cdb_rob[l]   = ROB_DEPTH'(lane_q[l].rob);
            cdb_rd_v[l]  = lane_q[l].v;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard testbench for cdb_arbiter
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int L  = 3;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          move_flush = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [RW-1:0] req_rob [N];
    logic [31:0]   req_v   [N];
    logic [N-1:0]  req_ready;
    logic [L-1:0]  cdb_valid;
    logic [RW-1:0] cdb_rob  [L];
    logic [31:0]   cdb_rd_v [L];

    cdb_arbiter #(
        .N_REQ     (N),
        .CDB_SIZE  (L),
        .ROB_DEPTH (RW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .move_flush (move_flush),
        .req_valid  (req_valid),
        .req_rob    (req_rob),
        .req_v      (req_v),
        .req_ready  (req_ready),
        .cdb_valid  (cdb_valid),
        .cdb_rob    (cdb_rob),
        .cdb_rd_v   (cdb_rd_v)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        int            lane;
        logic [RW-1:0] rob;
        logic [31:0]   v;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   grant_cnt [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic set_req(input int i, input logic vld, input logic [RW-1:0] rob, input logic [31:0] v);
        req_valid[i] = vld;
        req_rob[i]   = rob;
        req_v[i]     = v;
    endtask

    task automatic set_all(input logic vld, input logic [31:0] vbase);
        for (int i = 0; i < N; i++) begin
            set_req(i, vld, RW'(i), vbase + 32'(i));
        end
    endtask

    // Expected broadcast for the cycle following the current one.
    task automatic expect_lane(input int lane, input logic [RW-1:0] rob, input logic [31:0] v);
        exp_t e;
        e.cyc  = cyc + 1;
        e.lane = lane;
        e.rob  = rob;
        e.v    = v;
        exp_q.push_back(e);
    endtask

    task automatic apply(input logic [N-1:0] exp_ready, input string name);
        #1;
        checks++;
        if (req_ready !== exp_ready) begin
            errors++;
            $display("FAIL %s: req_ready got %b want %b", name, req_ready, exp_ready);
        end
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] && req_valid[i]) grant_cnt[i]++;
        end
    endtask

    task automatic check_cdb_zero(input string name);
        for (int l = 0; l < L; l++) begin
            checks++;
            if (cdb_valid[l] !== 1'b0 || cdb_rob[l] !== '0 || cdb_rd_v[l] !== '0) begin
                errors++;
                $display("FAIL %s lane %0d: got valid %b rob %0d v %h want all zero",
                         name, l, cdb_valid[l], cdb_rob[l], cdb_rd_v[l]);
            end
        end
    endtask

    // Monitor: pops expected lane entries whenever the CDB shows a valid lane.
    always @(posedge clk) begin
        #2;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_lane: cycle %0d lane %0d rob %0d never broadcast",
                     exp_q[0].cyc, exp_q[0].lane, exp_q[0].rob);
            mon_e = exp_q.pop_front();
        end
        for (int l = 0; l < L; l++) begin
            checks++;
            if (cdb_valid[l] === 1'b1) begin
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.lane != l || cdb_rob[l] !== mon_e.rob || cdb_rd_v[l] !== mon_e.v) begin
                        errors++;
                        $display("FAIL cdb_lane cycle %0d: got lane %0d rob %0d v %h want lane %0d rob %0d v %h",
                                 cyc, l, cdb_rob[l], cdb_rd_v[l], mon_e.lane, mon_e.rob, mon_e.v);
                    end
                end else begin
                    errors++;
                    $display("FAIL unexpected_lane cycle %0d lane %0d: got rob %0d v %h want no broadcast",
                             cyc, l, cdb_rob[l], cdb_rd_v[l]);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].lane == l) begin
                errors++;
                $display("FAIL lane_not_valid cycle %0d lane %0d: got valid %b want 1 rob %0d",
                         cyc, l, cdb_valid[l], exp_q[0].rob);
                mon_e = exp_q.pop_front();
            end else if (cdb_rob[l] !== '0 || cdb_rd_v[l] !== '0) begin
                errors++;
                $display("FAIL idle_lane cycle %0d lane %0d: got rob %0d v %h want 0",
                         cyc, l, cdb_rob[l], cdb_rd_v[l]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            req_rob[i]   = '0;
            req_v[i]     = '0;
            grant_cnt[i] = 0;
        end

        // Reset cycle with everybody requesting: nothing may be granted.
        rst = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, RW'(i + 1), 32'h1111_0001 + 32'(i));
        apply(4'b0000, "ready_during_rst");

        // Test 1: all four valid, rr_ptr = 0 -> grant 0,1,2.
        @(negedge clk);
        rst = 1'b0;
        check_cdb_zero("reset_state");
        apply(4'b0111, "t1_all_valid");
        expect_lane(0, 3'd1, 32'h1111_0001);
        expect_lane(1, 3'd2, 32'h1111_0002);
        expect_lane(2, 3'd3, 32'h1111_0003);

        // Test 2: rr_ptr = 3, req3 held, req0/1 re-presented -> lane0 = req3.
        @(negedge clk);
        set_req(0, 1'b1, 3'd5, 32'h2222_0005);
        set_req(1, 1'b1, 3'd6, 32'h2222_0006);
        set_req(2, 1'b0, 3'd0, 32'h0);
        apply(4'b1011, "t2_wrap");
        expect_lane(0, 3'd4, 32'h1111_0004);
        expect_lane(1, 3'd5, 32'h2222_0005);
        expect_lane(2, 3'd6, 32'h2222_0006);

        // Test 3: rr_ptr = 2, only req2 valid.
        @(negedge clk);
        set_req(0, 1'b0, 3'd0, 32'h0);
        set_req(1, 1'b0, 3'd0, 32'h0);
        set_req(3, 1'b0, 3'd0, 32'h0);
        set_req(2, 1'b1, 3'd7, 32'hDEAD_BEEF);
        apply(4'b0100, "t3_single");
        expect_lane(0, 3'd7, 32'hDEAD_BEEF);

        // Idle cycle: pointer holds at 3.
        @(negedge clk);
        set_req(2, 1'b0, 3'd0, 32'h0);
        apply(4'b0000, "idle");

        // Test 4: all valid for four cycles starting at rr_ptr = 3.
        for (int i = 0; i < N; i++) grant_cnt[i] = 0;
        @(negedge clk);
        set_all(1'b1, 32'hA000_0000);
        apply(4'b1011, "t4_c0");
        expect_lane(0, 3'd3, 32'hA000_0003);
        expect_lane(1, 3'd0, 32'hA000_0000);
        expect_lane(2, 3'd1, 32'hA000_0001);
        @(negedge clk);
        apply(4'b1101, "t4_c1");
        expect_lane(0, 3'd2, 32'hA000_0002);
        expect_lane(1, 3'd3, 32'hA000_0003);
        expect_lane(2, 3'd0, 32'hA000_0000);
        @(negedge clk);
        apply(4'b1110, "t4_c2");
        expect_lane(0, 3'd1, 32'hA000_0001);
        expect_lane(1, 3'd2, 32'hA000_0002);
        expect_lane(2, 3'd3, 32'hA000_0003);
        @(negedge clk);
        apply(4'b0111, "t4_c3");
        expect_lane(0, 3'd0, 32'hA000_0000);
        expect_lane(1, 3'd1, 32'hA000_0001);
        expect_lane(2, 3'd2, 32'hA000_0002);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (grant_cnt[i] < 3) begin
                errors++;
                $display("FAIL t4_fairness req %0d: got %0d grants want >= 3", i, grant_cnt[i]);
            end
        end

        // Test 5: grant at t (rr_ptr = 3, only req1), flush at t+1.
        @(negedge clk);
        set_all(1'b0, 32'h0);
        set_req(1, 1'b1, 3'd5, 32'h5555_0005);
        apply(4'b0010, "t5_grant");
        expect_lane(0, 3'd5, 32'h5555_0005);
        @(negedge clk);
        set_all(1'b1, 32'hB000_0000);
        move_flush = 1'b1;
        apply(4'b0000, "t5_flush_ready");
        @(negedge clk);
        move_flush = 1'b0;
        check_cdb_zero("t5_after_flush");
        apply(4'b0111, "t5_ptr_cleared");
        expect_lane(0, 3'd0, 32'hB000_0000);
        expect_lane(1, 3'd1, 32'hB000_0001);
        expect_lane(2, 3'd2, 32'hB000_0002);

        // Test 6: reset while lanes are valid, then restart from requester 0.
        @(negedge clk);
        apply(4'b1011, "t6_pre_rst");
        expect_lane(0, 3'd3, 32'hB000_0003);
        expect_lane(1, 3'd0, 32'hB000_0000);
        expect_lane(2, 3'd1, 32'hB000_0001);
        @(negedge clk);
        rst = 1'b1;
        move_flush = 1'b1;
        apply(4'b0000, "t6_ready_in_rst");
        @(negedge clk);
        rst = 1'b0;
        move_flush = 1'b0;
        check_cdb_zero("t6_after_rst");
        apply(4'b0111, "t6_restart");
        expect_lane(0, 3'd0, 32'hB000_0000);
        expect_lane(1, 3'd1, 32'hB000_0001);
        expect_lane(2, 3'd2, 32'hB000_0002);

        // Drain.
        @(negedge clk);
        set_all(1'b0, 32'h0);
        apply(4'b0000, "drain0");
        @(negedge clk);
        apply(4'b0000, "drain1");
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d pending entries want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
